// File: rtl/line_buffer_multi.sv
// Multi-line pixel buffer: KERNEL_SIZE+1 rotating line memories, one aligned column out per pixel, 3-cycle latency.
// Optional top-of-frame zero padding is compiled in with `define LINE_BUFFER_ZERO_PAD_EN.
module line_buffer_multi #(
  parameter int PIXEL_WIDTH = 1,
  parameter int H_PIXELS    = 320,
  parameter int V_LINES     = 240,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [10:0]                        hcount_in,
  input  logic [9:0]                         vcount_in,
  input  logic [PIXEL_WIDTH-1:0]             pixel_data_in,
  input  logic                               data_valid_in,
  output logic [KERNEL_SIZE*PIXEL_WIDTH-1:0] line_buffer_out,
  output logic [10:0]                        hcount_out,
  output logic [9:0]                         vcount_out,
  output logic                               data_valid_out
);

  localparam int NUM_MEMS = KERNEL_SIZE + 1;
  localparam int SEL_W    = $clog2(NUM_MEMS);
  localparam int ADDR_W   = $clog2(H_PIXELS);
  localparam int V_OFFSET = (KERNEL_SIZE + 1) / 2;
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(KERNEL_SIZE);
  localparam logic [10:0]      H_LIMIT = 11'(H_PIXELS);
  localparam logic [10:0]      V_LIMIT = 11'(V_LINES);
  localparam logic [10:0]      V_BIAS  = 11'(V_LINES - V_OFFSET);

  logic              in_range;
  logic              new_line;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [SEL_W-1:0]  wr_sel;
  logic [SEL_W-1:0]  sel_now;

  assign in_range = (hcount_in < H_LIMIT);
  assign new_line = data_valid_in && (hcount_in == 11'd0);
  assign wr_en    = data_valid_in && in_range;
  // Out-of-range columns still read, but from a safe address; their output is flagged invalid.
  assign addr     = in_range ? hcount_in[ADDR_W-1:0] : '0;

  // The rotation takes effect in the same cycle as the new-line pixel, so pixel 0 lands in the fresh memory.
  always_comb begin
    sel_now = wr_sel;
    if (new_line) sel_now = (wr_sel == SEL_MAX) ? '0 : wr_sel + SEL_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) wr_sel <= '0;
    else        wr_sel <= sel_now;
  end

  logic [NUM_MEMS*PIXEL_WIDTH-1:0] rd_flat;

  for (genvar m = 0; m < NUM_MEMS; m++) begin : g_mem
    logic [PIXEL_WIDTH-1:0] mem [H_PIXELS];
    logic [PIXEL_WIDTH-1:0] rd_q1;
    logic [PIXEL_WIDTH-1:0] rd_q2;

    // NOTE: line memories and their read registers have no reset so they map onto block RAM.
    always_ff @(posedge clk_in) begin
      if (wr_en && (sel_now == SEL_W'(m))) mem[addr] <= pixel_data_in;
      rd_q1 <= mem[addr];
      rd_q2 <= rd_q1;
    end

    assign rd_flat[m*PIXEL_WIDTH +: PIXEL_WIDTH] = rd_q2;
  end

  // Side-band pipeline matching the two memory read stages.
  logic [10:0]      h_a, h_b;
  logic [9:0]       v_a, v_b;
  logic             val_a, val_b;
  logic [SEL_W-1:0] sel_a, sel_b;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      h_a   <= '0;
      v_a   <= '0;
      val_a <= 1'b0;
      sel_a <= '0;
      h_b   <= '0;
      v_b   <= '0;
      val_b <= 1'b0;
      sel_b <= '0;
    end else begin
      h_a   <= hcount_in;
      v_a   <= vcount_in;
      val_a <= wr_en;
      sel_a <= sel_now;
      h_b   <= h_a;
      v_b   <= v_a;
      val_b <= val_a;
      sel_b <= sel_a;
    end
  end

  logic [KERNEL_SIZE*PIXEL_WIDTH-1:0] slots;
  logic [10:0]                        v_wide;
  logic [9:0]                         v_centre;

  // Slot i reads the memory written i+1 rotations before the one active when the address was issued.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin : slot_mux
    int idx;
    slots = '0;
    idx   = 0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      idx = int'(sel_b) + KERNEL_SIZE - i;
      if (idx >= NUM_MEMS) idx = idx - NUM_MEMS;
      slots[i*PIXEL_WIDTH +: PIXEL_WIDTH] = rd_flat[idx*PIXEL_WIDTH +: PIXEL_WIDTH];
`ifdef LINE_BUFFER_ZERO_PAD_EN
      if (int'(v_b) <= i) slots[i*PIXEL_WIDTH +: PIXEL_WIDTH] = '0;
`endif
    end
  end

  always_comb begin
    v_wide = {1'b0, v_b} + V_BIAS;
    if (v_wide >= V_LIMIT) v_wide = v_wide - V_LIMIT;
    v_centre = v_wide[9:0];
  end

  // Invalid cycles present all-zero fields so stale reads never leak after reset or during gaps.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      line_buffer_out <= '0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      data_valid_out  <= 1'b0;
    end else begin
      line_buffer_out <= val_b ? slots    : '0;
      hcount_out      <= val_b ? h_b      : '0;
      vcount_out      <= val_b ? v_centre : '0;
      data_valid_out  <= val_b;
    end
  end

endmodule

// File: tb/tb_line_buffer_multi.sv
// Directed bench for line_buffer_multi: a default 1-bit/3-line instance and an 8-bit/5-line instance.
module tb_line_buffer_multi;

`ifdef LINE_BUFFER_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int LOGN = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int failures = 0;

  // Instance A: defaults.
  logic        rst_a, dva;
  logic [10:0] ha;
  logic [9:0]  va;
  logic [0:0]  pa;
  logic [2:0]  lb_a;
  logic [10:0] ho_a;
  logic [9:0]  vo_a;
  logic        dvo_a;

  line_buffer_multi u_a (
    .clk_in(clk), .rst_in(rst_a), .hcount_in(ha), .vcount_in(va),
    .pixel_data_in(pa), .data_valid_in(dva),
    .line_buffer_out(lb_a), .hcount_out(ho_a), .vcount_out(vo_a), .data_valid_out(dvo_a)
  );

  // Instance B: 8-bit pixels, 5-line kernel, small frame.
  logic        rst_b, dvb;
  logic [10:0] hb;
  logic [9:0]  vb;
  logic [7:0]  pb;
  logic [39:0] lb_b;
  logic [10:0] ho_b;
  logic [9:0]  vo_b;
  logic        dvo_b;

  line_buffer_multi #(.PIXEL_WIDTH(8), .H_PIXELS(16), .V_LINES(8), .KERNEL_SIZE(5)) u_b (
    .clk_in(clk), .rst_in(rst_b), .hcount_in(hb), .vcount_in(vb),
    .pixel_data_in(pb), .data_valid_in(dvb),
    .line_buffer_out(lb_b), .hcount_out(ho_b), .vcount_out(vo_b), .data_valid_out(dvo_b)
  );

  logic [2:0]  la_lb [LOGN];
  logic [10:0] la_h  [LOGN];
  logic [9:0]  la_v  [LOGN];
  logic        la_dv [LOGN];
  logic [39:0] lg_b_lb [LOGN];
  logic [10:0] lg_b_h  [LOGN];
  logic [9:0]  lg_b_v  [LOGN];
  logic        lg_b_dv [LOGN];

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      la_lb[cyc]   = lb_a;
      la_h[cyc]    = ho_a;
      la_v[cyc]    = vo_a;
      la_dv[cyc]   = dvo_a;
      lg_b_lb[cyc] = lb_b;
      lg_b_h[cyc]  = ho_b;
      lg_b_v[cyc]  = vo_b;
      lg_b_dv[cyc] = dvo_b;
    end
  end

  int a_cyc [320];
  int b_cyc [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input int h, input int v, input bit val, input bit p, input bit r, output int c);
    ha = 11'(h); va = 10'(v); dva = val; pa = p; rst_a = r;
    c = cyc;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input int h, input int v, input bit val, input logic [7:0] p, output int c);
    hb = 11'(h); vb = 10'(v); dvb = val; pb = p;
    c = cyc;
    @(posedge clk); #1;
  endtask

  task automatic line_a(input int v);
    for (int h = 0; h < 320; h++) step_a(h, v, 1'b1, 1'((h + v) & 1), 1'b0, a_cyc[h]);
  endtask

  task automatic line_b(input int v, input bit ff);
    for (int h = 0; h < 16; h++) step_b(h, v, 1'b1, ff ? 8'hFF : 8'(v * 10 + h), b_cyc[h]);
  endtask

  // Output of the input issued at cycle c appears in the log three cycles later.
  task automatic chk_a(input string tag, input int c, input bit use_lb, input logic [2:0] lb,
                       input int hc, input int vc, input bit dv);
    if (use_lb) check({tag, "_lb"}, 64'(la_lb[c+3]), 64'(lb));
    check({tag, "_h"},  64'(la_h[c+3]),  64'(hc));
    check({tag, "_v"},  64'(la_v[c+3]),  64'(vc));
    check({tag, "_dv"}, 64'(la_dv[c+3]), 64'(dv));
  endtask

  task automatic chk_b(input string tag, input int c, input logic [39:0] lb, input int vc);
    check({tag, "_lb"}, 64'(lg_b_lb[c+3]), 64'(lb));
    check({tag, "_h"},  64'(lg_b_h[c+3]),  64'd3);
    check({tag, "_v"},  64'(lg_b_v[c+3]),  64'(vc));
    check({tag, "_dv"}, 64'(lg_b_dv[c+3]), 64'd1);
  endtask

  initial begin
    int c, g0, g1, oc, rc;
    rst_a = 1'b1; ha = '0; va = '0; pa = '0; dva = 1'b0;
    rst_b = 1'b1; hb = '0; vb = '0; pb = '0; dvb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    check("rst_a_lb", 64'(lb_a), 64'd0);
    check("rst_a_h",  64'(ho_a), 64'd0);
    check("rst_a_v",  64'(vo_a), 64'd0);
    check("rst_a_dv", 64'(dvo_a), 64'd0);
    check("rst_b_lb", 64'(lb_b), 64'd0);
    check("rst_b_dv", 64'(dvo_b), 64'd0);

    // Frame top: centre row wraps to the end of the previous frame.
    line_a(0);
    chk_a("a_v0", a_cyc[5], PAD, 3'b000, 5, 238, 1'b1);
    line_a(1);
    chk_a("a_v1", a_cyc[5], PAD, 3'b001, 5, 239, 1'b1);
    line_a(2);
    line_a(3);
    chk_a("a_v3", a_cyc[5], 1'b1, 3'b101, 5, 1, 1'b1);

    // Two-cycle valid gap at h=100 on line 4.
    for (int h = 0; h < 100; h++) step_a(h, 4, 1'b1, 1'((h + 4) & 1), 1'b0, a_cyc[h]);
    step_a(100, 4, 1'b0, 1'b0, 1'b0, g0);
    step_a(100, 4, 1'b0, 1'b0, 1'b0, g1);
    for (int h = 100; h < 320; h++) step_a(h, 4, 1'b1, 1'((h + 4) & 1), 1'b0, a_cyc[h]);
    check("gap_pre_dv", 64'(la_dv[a_cyc[99]+3]), 64'd1);
    check("gap0_dv",    64'(la_dv[g0+3]), 64'd0);
    check("gap1_dv",    64'(la_dv[g1+3]), 64'd0);
    chk_a("gap_h100", a_cyc[100], 1'b1, 3'b101, 100, 2, 1'b1);
    chk_a("gap_h101", a_cyc[101], 1'b1, 3'b010, 101, 2, 1'b1);

    // Out-of-range column carrying the inverse of pixel (4,5) must neither write nor be valid.
    line_a(5);
    step_a(324, 5, 1'b1, 1'b0, 1'b0, oc);
    check("oor_dv", 64'(la_dv[oc+3]), 64'd0);
    line_a(6);
    chk_a("oor_reread", a_cyc[4], 1'b1, 3'b101, 4, 4, 1'b1);

    // Reset at h=150 of line 10, then restart at (0,0).
    line_a(7);
    line_a(8);
    line_a(9);
    for (int h = 0; h < 150; h++) step_a(h, 10, 1'b1, 1'((h + 10) & 1), 1'b0, c);
    step_a(150, 10, 1'b1, 1'b0, 1'b1, rc);
    line_a(0);
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("mrst%0d_lb", k), 64'(la_lb[rc+k]), 64'd0);
      check($sformatf("mrst%0d_h", k),  64'(la_h[rc+k]),  64'd0);
      check($sformatf("mrst%0d_v", k),  64'(la_v[rc+k]),  64'd0);
      check($sformatf("mrst%0d_dv", k), 64'(la_dv[rc+k]), 64'd0);
    end
    chk_a("restart_v0", a_cyc[5], PAD, 3'b000, 5, 238, 1'b1);
    line_a(1);
    line_a(2);
    line_a(3);
    chk_a("restart_v3", a_cyc[5], 1'b1, 3'b101, 5, 1, 1'b1);

    // Instance B: a frame of 0xFF, then two frames of v*10+h.
    for (int v = 0; v < 8; v++) line_b(v, 1'b1);
    line_b(0, 1'b0);
    chk_b("b_f2_v0", b_cyc[3], PAD ? 40'h0 : 40'hFFFFFFFFFF, 5);
    line_b(1, 1'b0);
    chk_b("b_f2_v1", b_cyc[3], PAD ? 40'h0000000003 : 40'hFFFFFFFF03, 6);
    line_b(2, 1'b0);
    line_b(3, 1'b0);
    chk_b("b_f2_v3", b_cyc[3], PAD ? 40'h0000030D17 : 40'hFFFF030D17, 0);
    for (int v = 4; v < 7; v++) line_b(v, 1'b0);
    chk_b("b_f2_v6", b_cyc[3], 40'h0D17212B35, 3);
    line_b(7, 1'b0);
    line_b(0, 1'b0);
    chk_b("b_f3_v0", b_cyc[3], PAD ? 40'h0 : 40'h212B353F49, 5);
    for (int v = 1; v < 7; v++) line_b(v, 1'b0);
    chk_b("b_f3_v6", b_cyc[3], 40'h0D17212B35, 3);

    step_b(0, 0, 1'b0, 8'h00, c);
    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_buffer_multi.md
# line_buffer_multi

Parametrised multi-line pixel buffer for streaming convolution and morphology kernels. It accepts one pixel per valid cycle in raster order and stores the most recent KERNEL_SIZE completed lines in rotating line memories. For every input pixel it presents the vertically aligned column of KERNEL_SIZE pixels, plus the matching hcount, vcount and valid, 3 cycles later. It replaces the fixed 1-bit, 3-line buffer ahead of the filter and edge-detect stages, and adds arbitrary pixel width and kernel height, coherent output timing and top-of-frame handling.

## Interface
Parameters:
- PIXEL_WIDTH, 1: bits per pixel.
- H_PIXELS, 320: pixels per line; line memory depth.
- V_LINES, 240: lines per frame; modulus for vcount_out.
- KERNEL_SIZE, 3: lines presented per output column (≥2).

Ports:
- clk_in  input  1  system clock; one clock.
- rst_in  input  1  reset; synchronous, active-high.
- hcount_in  input  11  column of incoming pixel.
- vcount_in  input  10  line of incoming pixel.
- pixel_data_in  input  PIXEL_WIDTH  incoming pixel.
- data_valid_in  input  1  pixel_data_in valid this cycle.
- line_buffer_out  output  KERNEL_SIZE*PIXEL_WIDTH  packed column; slot i = bits [i*PIXEL_WIDTH +: PIXEL_WIDTH].
- hcount_out  output  11  column of line_buffer_out.
- vcount_out  output  10  centre-row line number of line_buffer_out.
- data_valid_out  output  1  outputs valid this cycle.

## Operation
- The block holds KERNEL_SIZE+1 line memories. Each memory is H_PIXELS deep and PIXEL_WIDTH wide, read-first, with 2-cycle read latency. Port A only.
- wr_sel (0..KERNEL_SIZE) selects the memory being written. It resets to 0.
- A new line occurs when data_valid_in=1 and hcount_in=0.
  - On a new line, wr_sel advances before that pixel is written: KERNEL_SIZE wraps to 0.
  - Pixel (0, v) therefore lands in the new memory.
- Write: when data_valid_in=1 and hcount_in<H_PIXELS, the block writes pixel_data_in to address hcount_in of memory wr_sel in the same cycle.
- Read: every memory is read at address hcount_in every cycle.
- Output slot i (0 = most recently completed line, KERNEL_SIZE-1 = oldest) is taken from memory (wr_sel − 1 − i) mod (KERNEL_SIZE+1).
  - The mux uses the wr_sel value from the cycle the address was issued, delayed 2 cycles.
  - A rotation therefore never corrupts in-flight reads.
- For input at (h, v), slot i holds pixel (h, v−1−i).
- vcount_out = (v − (KERNEL_SIZE+1)/2) mod V_LINES (integer division). For KERNEL_SIZE=3, v=0 gives 238 and v=1 gives 239.
- Input with hcount_in ≥ H_PIXELS:
  - no write occurs;
  - hcount_in=0 rotation rules are unchanged;
  - the output cycle carries data_valid_out=0.
- Cycles with data_valid_in=0 write nothing, do not rotate, and produce data_valid_out=0 three cycles later.

## Timing
- Fixed latency of 3 cycles from an input cycle to its output cycle (2 memory cycles + 1 output register).
  - line_buffer_out, hcount_out, vcount_out and data_valid_out are all taken from the same input cycle.
  - There is no per-field skew.
- No backpressure. Input may be valid every cycle.
- Reset:
  - line_buffer_out=0, hcount_out=0, vcount_out=0, data_valid_out=0, wr_sel=0;
  - the delay pipeline is cleared, so data_valid_out stays 0 for 3 cycles after reset releases;
  - memory contents are not cleared.
- Reset mid-line: pixels in flight are discarded. The next accepted pixel writes memory 0 unless it is a new line, in which case it writes memory 1.
- A new line on consecutive valid cycles (two hcount_in=0 pixels back to back) rotates twice.

## Configuration
- LINE_BUFFER_ZERO_PAD_EN defined:
  - slot i is forced to 0 whenever the pipelined v ≤ i, i.e. the row lies above the top of the current frame;
  - this prevents previous-frame or post-reset data from entering the kernel.
- LINE_BUFFER_ZERO_PAD_EN undefined:
  - slots always carry raw memory contents;
  - rows above the frame top hold stale data;
  - no comparison logic is generated.

## Test plan
- Defaults. Write 4 lines, pixel(h,v)=(h+v)&1. At input (5,3), output 3 cycles later: slots {0,1,2}={pixel(5,2),(5,1),(5,0)}={1,0,1}, hcount_out=5, vcount_out=1, data_valid_out=1.
- PIXEL_WIDTH=8, KERNEL_SIZE=5. Pixel=v*10+h over 7 lines. At (3,6): slots 0..4 = 53,43,33,23,13; vcount_out=3. Over ≥2 frames, rotation wraps wr_sel 5→0 with no data loss.
- Valid gaps. Deassert data_valid_in for 2 cycles mid-line at h=100. Output has exactly 2 invalid cycles at the matching position, and slots at h=101 are correct.
- Start of frame at v=0 after a prior frame of 0xFF. With LINE_BUFFER_ZERO_PAD_EN, slots 0..2 are 0 at v=0, slot 0 is nonzero from v=1, and all slots are live from v=3. Without the macro, slots show 0xFF.
- Assert reset at h=150 of line 10. All outputs are 0 and data_valid_out=0 for 3 cycles. Restarting at (0,0) gives correct slots by v=3.
- hcount_in=H_PIXELS+4 with valid=1. No write occurs (re-reading the next line shows the original data), and the corresponding data_valid_out=0.
